motor_cmd_rx: RTL and testbench

//  Serial command receiver that drives the dual motor driver's command inputs.

---
 rtl/motor_cmd_rx_pkg.sv | 30 +++
 rtl/motor_cmd_rx_uart_rx_byte.sv | 117 +++++++++++
 rtl/motor_cmd_rx.sv | 126 ++++++++++++
 tb/tb_motor_cmd_rx.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/motor_cmd_rx_pkg.sv
`default_nettype none
// ============================================================================
// motor_cmd_rx_pkg : frame constants, FSM encodings and the shared checksum.
// Rev 1.0
// ============================================================================
package motor_cmd_rx_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [1:0] {
    HUNT     = 2'd0,
    WAIT_A   = 2'd1,
    WAIT_B   = 2'd2,
    WAIT_CHK = 2'd3
  } frame_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } byte_state_t;

  // The TX-side firmware model computes its CHK byte with this same function.
  function automatic logic [7:0] chk(input logic [7:0] a, input logic [7:0] b);
    return SYNC_BYTE ^ a ^ b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/motor_cmd_rx_uart_rx_byte.sv
`default_nettype none
// ============================================================================
// uart_rx_byte : rx synchroniser plus 8N1 byte receiver.
// Rev 1.0
// ============================================================================
module uart_rx_byte
  import motor_cmd_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 139
) (
  input  logic       clk_16mhz,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] byteData,
  output logic       byteValid,
  output logic       framingErr,
  output logic       lineIdle
);

  localparam int            CW      = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  logic          rx_meta;
  logic          rx_sync;
  byte_state_t   state;
  byte_state_t   state_nxt;
  logic [CW-1:0] clk_cnt;
  logic [CW-1:0] clk_cnt_nxt;
  logic [2:0]    bit_cnt;
  logic [2:0]    bit_cnt_nxt;
  logic [7:0]    shift;
  logic [7:0]    shift_nxt;
  logic [7:0]    data_nxt;
  logic          valid_nxt;
  logic          ferr_nxt;

  // Preset to idle-high so reset release never looks like a start bit.
  always_ff @(posedge clk_16mhz or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  always_comb begin
    state_nxt   = state;
    clk_cnt_nxt = clk_cnt + 1'b1;
    bit_cnt_nxt = bit_cnt;
    shift_nxt   = shift;
    data_nxt    = byteData;
    valid_nxt   = 1'b0;
    ferr_nxt    = 1'b0;
    case (state)
      RX_IDLE: begin
        clk_cnt_nxt = '0;
        bit_cnt_nxt = '0;
        if (!rx_sync) state_nxt = RX_START;
      end
      RX_START: begin
        if (clk_cnt == HALF_M1) begin
          clk_cnt_nxt = '0;
          state_nxt   = rx_sync ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (clk_cnt == FULL_M1) begin
          clk_cnt_nxt = '0;
          shift_nxt   = {rx_sync, shift[7:1]};
          bit_cnt_nxt = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_nxt = RX_STOP;
        end
      end
      RX_STOP: begin
        // Back to idle on the sample itself so a start bit right after is caught.
        if (clk_cnt == FULL_M1) begin
          clk_cnt_nxt = '0;
          state_nxt   = RX_IDLE;
          if (rx_sync) begin
            valid_nxt = 1'b1;
            data_nxt  = shift;
          end else begin
            ferr_nxt  = 1'b1;
          end
        end
      end
      default: state_nxt = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk_16mhz or posedge reset) begin
    if (reset) begin
      state      <= RX_IDLE;
      clk_cnt    <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      byteData   <= '0;
      byteValid  <= 1'b0;
      framingErr <= 1'b0;
    end else begin
      state      <= state_nxt;
      clk_cnt    <= clk_cnt_nxt;
      bit_cnt    <= bit_cnt_nxt;
      shift      <= shift_nxt;
      byteData   <= data_nxt;
      byteValid  <= valid_nxt;
      framingErr <= ferr_nxt;
    end
  end

  assign lineIdle = (state == RX_IDLE);

endmodule
`default_nettype wire

// File: rtl/motor_cmd_rx.sv
`default_nettype none
// ============================================================================
// motor_cmd_rx : UART frame parser driving the dual motor speed commands.
// Rev 1.0
// ============================================================================
module motor_cmd_rx
  import motor_cmd_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 139,
  parameter int GAP_TIMEOUT  = 4096
) (
  input  logic              clk_16mhz,
  input  logic              reset,
  input  logic              rx,
  output logic signed [7:0] speedA,
  output logic signed [7:0] speedB,
  output logic              aliveStrobe,
  output logic              chkErr,
  output logic              framingErr
);

  localparam int            GW     = $clog2(GAP_TIMEOUT) + 1;
  localparam logic [GW-1:0] GAP_M1 = GW'(GAP_TIMEOUT - 1);

  logic [7:0]   byte_data;
  logic         byte_valid;
  logic         line_idle;
  frame_state_t frame_state;
  frame_state_t frame_nxt;
  logic [7:0]   tmp_a;
  logic [7:0]   tmp_b;
  logic [7:0]   tmp_a_nxt;
  logic [7:0]   tmp_b_nxt;
  logic         accept;
  logic         chk_fail;
  logic [GW-1:0] gap_cnt;
  logic         gap_run;
  logic         gap_hit;

  uart_rx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_rx (
    .clk_16mhz  (clk_16mhz),
    .reset      (reset),
    .rx         (rx),
    .byteData   (byte_data),
    .byteValid  (byte_valid),
    .framingErr (framingErr),
    .lineIdle   (line_idle)
  );

  assign gap_run = (frame_state != HUNT) && line_idle;
  assign gap_hit = gap_run && (gap_cnt == GAP_M1);

  // byte_valid and framingErr come from one stop sample, so they never coincide.
  always_comb begin
    frame_nxt = frame_state;
    tmp_a_nxt = tmp_a;
    tmp_b_nxt = tmp_b;
    accept    = 1'b0;
    chk_fail  = 1'b0;
    if (framingErr) begin
      frame_nxt = HUNT;
    end else if (byte_valid) begin
      case (frame_state)
        HUNT:     if (byte_data == SYNC_BYTE) frame_nxt = WAIT_A;
        WAIT_A: begin
          tmp_a_nxt = byte_data;
          frame_nxt = WAIT_B;
        end
        WAIT_B: begin
          tmp_b_nxt = byte_data;
          frame_nxt = WAIT_CHK;
        end
        WAIT_CHK: begin
          frame_nxt = HUNT;
          if (byte_data == chk(tmp_a, tmp_b)) accept   = 1'b1;
          else                                chk_fail = 1'b1;
        end
        default:  frame_nxt = HUNT;
      endcase
    end else if (gap_hit) begin
      frame_nxt = HUNT;
    end
  end

  always_ff @(posedge clk_16mhz or posedge reset) begin
    if (reset) begin
      frame_state <= HUNT;
      tmp_a       <= '0;
      tmp_b       <= '0;
    end else begin
      frame_state <= frame_nxt;
      tmp_a       <= tmp_a_nxt;
      tmp_b       <= tmp_b_nxt;
    end
  end

  always_ff @(posedge clk_16mhz or posedge reset) begin
    if (reset) begin
      gap_cnt <= '0;
    end else if (byte_valid || !gap_run || gap_hit) begin
      gap_cnt <= '0;
    end else begin
      gap_cnt <= gap_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_16mhz or posedge reset) begin
    if (reset) begin
      speedA      <= '0;
      speedB      <= '0;
      aliveStrobe <= 1'b0;
      chkErr      <= 1'b0;
    end else begin
      chkErr <= chk_fail;
      if (accept) begin
        speedA      <= tmp_a;
        speedB      <= tmp_b;
        aliveStrobe <= ~aliveStrobe;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_motor_cmd_rx.sv
`default_nettype none
// ============================================================================
// tb_motor_cmd_rx : directed frame vectors for motor_cmd_rx.
// Rev 1.0
// ============================================================================
module tb_motor_cmd_rx;

  localparam int CPB = 16;
  localparam int GAP = 64;

  typedef struct {
    logic [7:0] b [5];
    int         n;
    bit         acc;
    logic [7:0] ea;
    logic [7:0] eb;
    int         n_chkerr;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic [7:0] speedA;
  logic [7:0] speedB;
  logic       aliveStrobe;
  logic       chkErr;
  logic       framingErr;

  int errors = 0;
  int checks = 0;
  int n_chk  = 0;
  int n_fe   = 0;
  int n_both = 0;

  logic [7:0] exp_a = 8'h00;
  logic [7:0] exp_b = 8'h00;
  logic       exp_s = 1'b0;

  vec_t tbl [4];

  always #5 clk = ~clk;

  motor_cmd_rx #(
    .CLKS_PER_BIT (CPB),
    .GAP_TIMEOUT  (GAP)
  ) dut (
    .clk_16mhz   (clk),
    .reset       (reset),
    .rx          (rx),
    .speedA      (speedA),
    .speedB      (speedB),
    .aliveStrobe (aliveStrobe),
    .chkErr      (chkErr),
    .framingErr  (framingErr)
  );

  always @(negedge clk) begin
    if (chkErr)               n_chk  <= n_chk + 1;
    if (framingErr)           n_fe   <= n_fe + 1;
    if (chkErr && framingErr) n_both <= n_both + 1;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  function automatic vec_t mk(input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3,
                              input logic [7:0] b4, input int n, input bit acc,
                              input logic [7:0] ea, input logic [7:0] eb,
                              input int nce);
    vec_t v;
    v.b[0] = b0; v.b[1] = b1; v.b[2] = b2; v.b[3] = b3; v.b[4] = b4;
    v.n = n; v.acc = acc; v.ea = ea; v.eb = eb; v.n_chkerr = nce;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Called at a negedge; each bit lasts CPB clocks.
  task automatic send_bits(input logic [7:0] d, input logic stop_val, input int stop_cycles);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_val;
    repeat (stop_cycles) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] d);
    send_bits(d, 1'b1, CPB);
  endtask

  // Last stop bit is split so the output change is checked to the exact clock.
  task automatic run_vec(input vec_t v, input string tag);
    int c0;
    int f0;
    logic [7:0] na;
    logic [7:0] nb;
    c0 = n_chk;
    f0 = n_fe;
    na = v.acc ? v.ea : exp_a;
    nb = v.acc ? v.eb : exp_b;
    for (int i = 0; i < v.n - 1; i++) send_byte(v.b[i]);
    send_bits(v.b[v.n-1], 1'b1, CPB - 5);
    check({tag, "_holdA"}, {24'd0, speedA}, {24'd0, exp_a});
    check({tag, "_holdB"}, {24'd0, speedB}, {24'd0, exp_b});
    check({tag, "_holdS"}, {31'd0, aliveStrobe}, {31'd0, exp_s});
    @(negedge clk);
    exp_a = na;
    exp_b = nb;
    if (v.acc) exp_s = ~exp_s;
    check({tag, "_speedA"}, {24'd0, speedA}, {24'd0, exp_a});
    check({tag, "_speedB"}, {24'd0, speedB}, {24'd0, exp_b});
    check({tag, "_strobe"}, {31'd0, aliveStrobe}, {31'd0, exp_s});
    repeat (4) @(negedge clk);
    check({tag, "_chkErr_cnt"}, 32'(n_chk - c0), 32'(v.n_chkerr));
    check({tag, "_framingErr_cnt"}, 32'(n_fe - f0), 32'd0);
  endtask

  initial begin
    int c0;
    int f0;

    tbl[0] = mk(8'hA5, 8'h40, 8'hC0, 8'h25, 8'h00, 4, 1'b1, 8'h40, 8'hC0, 0);
    tbl[1] = mk(8'hA5, 8'h10, 8'h20, 8'h00, 8'h00, 4, 1'b0, 8'h00, 8'h00, 1);
    tbl[2] = mk(8'hA5, 8'h10, 8'h20, 8'h95, 8'h00, 4, 1'b1, 8'h10, 8'h20, 0);
    tbl[3] = mk(8'h00, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 5, 1'b1, 8'hA5, 8'hA5, 0);

    reset = 1'b1;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_speedA", {24'd0, speedA}, 32'd0);
    check("rst_speedB", {24'd0, speedB}, 32'd0);
    check("rst_strobe", {31'd0, aliveStrobe}, 32'd0);
    check("rst_chkErr", {31'd0, chkErr}, 32'd0);
    check("rst_framingErr", {31'd0, framingErr}, 32'd0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    for (int k = 0; k < 4; k++) run_vec(tbl[k], $sformatf("vec%0d", k));

    // Low stop bit on speedB, next frame sent straight after.
    f0 = n_fe;
    c0 = n_chk;
    send_byte(8'hA5);
    send_byte(8'h40);
    send_bits(8'hC0, 1'b0, CPB);
    check("fe_pulse_cnt", 32'(n_fe - f0), 32'd1);
    check("fe_holdA", {24'd0, speedA}, {24'd0, exp_a});
    check("fe_holdB", {24'd0, speedB}, {24'd0, exp_b});
    run_vec(mk(8'hA5, 8'h11, 8'h22, 8'h96, 8'h00, 4, 1'b1, 8'h11, 8'h22, 0), "after_fe");
    check("fe_no_chkErr", 32'(n_chk - c0), 32'd0);

    // Short glitch, then a frame broken by an idle gap longer than the timeout.
    f0 = n_fe;
    c0 = n_chk;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_fe_cnt", 32'(n_fe - f0), 32'd0);
    send_byte(8'hA5);
    repeat (100) @(negedge clk);
    send_byte(8'h10);
    send_byte(8'h20);
    send_byte(8'h95);
    repeat (4) @(negedge clk);
    check("gap_speedA", {24'd0, speedA}, {24'd0, exp_a});
    check("gap_speedB", {24'd0, speedB}, {24'd0, exp_b});
    check("gap_strobe", {31'd0, aliveStrobe}, {31'd0, exp_s});
    check("gap_chkErr_cnt", 32'(n_chk - c0), 32'd0);
    check("gap_fe_cnt", 32'(n_fe - f0), 32'd0);

    // Reset in the middle of the speedA byte data bits.
    send_byte(8'hA5);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    check("midrst_speedA", {24'd0, speedA}, 32'd0);
    check("midrst_speedB", {24'd0, speedB}, 32'd0);
    check("midrst_strobe", {31'd0, aliveStrobe}, 32'd0);
    exp_a = 8'h00;
    exp_b = 8'h00;
    exp_s = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2 * CPB) @(negedge clk);
    run_vec(mk(8'hA5, 8'h7F, 8'h81, 8'h5B, 8'h00, 4, 1'b1, 8'h7F, 8'h81, 0), "after_rst");

    check("err_overlap", 32'(n_both), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
